// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU sequencing controller.
package alu_pkg;

  // ALU control codes
  localparam logic [3:0] CTRL_NOP   = 4'h0;  // ALU default path
  localparam logic [3:0] CTRL_ADD   = 4'h1;
  localparam logic [3:0] CTRL_SUB   = 4'h2;
  localparam logic [3:0] CTRL_MUL   = 4'h4;
  localparam logic [3:0] CTRL_DIV   = 4'h8;
  localparam logic [3:0] CTRL_ANDI  = 4'hC;
  localparam logic [3:0] CTRL_ORI   = 4'hE;
  localparam logic [3:0] CTRL_ADDNF = 4'hF;

  // Exception codes
  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_DIV0 = 2'b10;
  localparam logic [1:0] EXC_ILL  = 2'b11;

  // Secondary results (mul high word, div remainder) always land in R0
  localparam logic [3:0] R0_ADDR = 4'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB1  = 2'd2,
    ST_WB2  = 2'd3
  } state_e;

  // True for every code the ALU implements
  function automatic logic ctrl_is_legal(input logic [3:0] ctrl);
    case (ctrl)
      CTRL_ADD, CTRL_SUB, CTRL_MUL, CTRL_DIV,
      CTRL_ANDI, CTRL_ORI, CTRL_ADDNF: ctrl_is_legal = 1'b1;
      default:                         ctrl_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op decode: legality, EXEC latency (minus one) and whether
// the op produces a second result destined for R0.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int CW         = 3
) (
  input  logic [3:0]    ctrl_i,
  output logic          legal_o,
  output logic [CW-1:0] lat_m1_o,
  output logic          two_result_o
);

  // Latency and result-count lookup per control code
  always_comb begin
    legal_o      = ctrl_is_legal(ctrl_i);
    lat_m1_o     = '0;
    two_result_o = 1'b0;
    case (ctrl_i)
      CTRL_MUL: begin
        lat_m1_o     = CW'(MUL_CYCLES - 1);
        two_result_o = 1'b1;
      end
      CTRL_DIV: begin
        lat_m1_o     = CW'(DIV_CYCLES - 1);
        two_result_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the signed ALU: accepts one op, holds the ALU
// inputs for the op latency, then writes back through the single RF port
// (two writes for mul/div) and pulses exceptions.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,      // active low, asynchronous
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_rd,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] alu_r0,
  input  logic             alu_ovf,
  output logic             wb_en,
  output logic [3:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             exc_valid,
  output logic [1:0]       exc_code
);

  localparam int MAXL = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       ctrl_q, rd_q;
  logic             two_q;
  logic [WIDTH-1:0] in1_q, in2_q;
  logic [WIDTH-1:0] r0_q;
  logic             ovf_q;

  logic             wb_en_q, wb_en_d;
  logic [3:0]       wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic             exc_valid_q, exc_valid_d;
  logic [1:0]       exc_code_q, exc_code_d;

  logic             dec_legal, dec_two;
  logic [CW-1:0]    dec_lat_m1;
  logic             accept, div0, start;

  alu_op_decode #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES),
    .CW        (CW)
  ) u_dec (
    .ctrl_i      (op_ctrl),
    .legal_o     (dec_legal),
    .lat_m1_o    (dec_lat_m1),
    .two_result_o(dec_two)
  );

  // A divide by zero is rejected at decode so the ALU never sees ctrl 8 with b==0
  assign accept = op_valid && (state_q == ST_IDLE);
  assign div0   = (op_ctrl == CTRL_DIV) && (op_b == '0);
  assign start  = accept && dec_legal && !div0;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; an overflowing op skips WB2 entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)          state_d = ST_EXEC;
      ST_EXEC: if (cnt_q == '0)    state_d = ST_WB1;
      ST_WB1:  state_d = (two_q && !ovf_q) ? ST_WB2 : ST_IDLE;
      ST_WB2:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: handshake/ALU control plus next values of registered wb/exc
  always_comb begin
    op_ready    = (state_q == ST_IDLE);
    alu_ctrl    = (state_q == ST_EXEC) ? ctrl_q : CTRL_NOP;
    wb_en_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    exc_valid_d = 1'b0;
    exc_code_d  = EXC_NONE;
    case (state_q)
      ST_IDLE: begin
        if (accept && !dec_legal) begin
          exc_valid_d = 1'b1;
          exc_code_d  = EXC_ILL;
        end else if (accept && div0) begin
          exc_valid_d = 1'b1;
          exc_code_d  = EXC_DIV0;
        end
      end
      ST_EXEC: begin
        // Registered so the WB1 write/exception is visible during the WB1 cycle
        if (cnt_q == '0) begin
          if (alu_ovf) begin
            exc_valid_d = 1'b1;
            exc_code_d  = EXC_OVF;
          end else begin
            wb_en_d   = 1'b1;
            wb_addr_d = rd_q;
            wb_data_d = alu_out;
          end
        end
      end
      ST_WB1: begin
        if (two_q && !ovf_q) begin
          wb_en_d   = 1'b1;
          wb_addr_d = R0_ADDR;
          wb_data_d = r0_q;
        end
      end
      default: ;
    endcase
  end

  // Operand latch, latency counter and result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      ctrl_q <= CTRL_NOP;
      rd_q   <= '0;
      two_q  <= 1'b0;
      in1_q  <= '0;
      in2_q  <= '0;
      r0_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (start) begin
        cnt_q  <= dec_lat_m1;
        ctrl_q <= op_ctrl;
        rd_q   <= op_rd;
        two_q  <= dec_two;
        in1_q  <= op_a;
        in2_q  <= op_b;
      end else if (state_q == ST_EXEC) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          r0_q  <= alu_r0;
          ovf_q <= alu_ovf;
        end
      end
    end
  end

  // Registered writeback and exception outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_code_q  <= EXC_NONE;
    end else begin
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      exc_valid_q <= exc_valid_d;
      exc_code_q  <= exc_code_d;
    end
  end

  assign alu_in1   = in1_q;
  assign alu_in2   = in2_q;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign exc_valid = exc_valid_q;
  assign exc_code  = exc_code_q;

endmodule
